// File: rtl/bidin_sram_arb_if.sv
// Bus bundle between the deinterleaver write/read requesters, the SRAM arbiter and the SRAM macro pins.
interface bidin_sram_arb_if #(
  parameter int WID = 6,
  parameter int AW  = 18
);
  logic           wr_vld;
  logic [AW-1:0]  wr_addr;
  logic [WID-1:0] wr_data;
  logic           rd_req;
  logic [AW-1:0]  rd_addr;
  logic           rd_gnt;
  logic           rd_vld;
  logic [WID-1:0] rd_data;
  logic [AW-1:0]  sram_addr;
  logic [WID-1:0] sram_din;
  logic [WID-1:0] sram_dout;
  logic           sram_en;
  logic           sram_wr;

  // Arbiter view.
  modport slave (
    input  wr_vld, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
    output rd_gnt, rd_vld, rd_data, sram_addr, sram_din, sram_en, sram_wr
  );

  // Requesters plus SRAM macro view.
  modport master (
    output wr_vld, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
    input  rd_gnt, rd_vld, rd_data, sram_addr, sram_din, sram_en, sram_wr
  );
endinterface

// File: rtl/bidin_sram_arb.sv
// Single-port deinterleaver SRAM arbiter: FIFO-buffered write stream vs. request/grant read stream.
// Optional read-after-write address check enabled by defining BIDIN_ARB_RAW_CHK_EN.
module bidin_sram_arb #(
  parameter int WID   = 6,
  parameter int AW    = 18,
  parameter int FD    = 4,
  parameter int HI_WM = 3
) (
  input  logic                clk6,
  input  logic                rst_n,
  bidin_sram_arb_if.slave     bus,
  output logic [$clog2(FD):0] fifo_cnt,
  output logic                wr_ovf
);
  localparam int PW = $clog2(FD);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
  typedef enum logic {LAST_WR, LAST_RD} last_e;

  logic [AW-1:0]  fifo_addr_q [FD];
  logic [WID-1:0] fifo_data_q [FD];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  last_e          last_q, last_d;
  logic           ovf_q, ovf_d;
  logic           sram_en_q, sram_en_d;
  logic           sram_wr_q, sram_wr_d;
  logic [AW-1:0]  sram_addr_q, sram_addr_d;
  logic [WID-1:0] sram_din_q, sram_din_d;
  logic           rd_vld_q, rd_vld_d;

  gnt_e gnt;
  logic fifo_ne, forced, rd_elig, push, pop, full, raw_hit;

`ifdef BIDIN_ARB_RAW_CHK_EN
  // An entry is live when its distance from the read pointer is below the occupancy.
  logic [FD-1:0] hit_vec;
  for (genvar gi = 0; gi < FD; gi++) begin : g_raw
    logic [PW-1:0] off;
    assign off         = PW'(gi) - rptr_q;
    assign hit_vec[gi] = (CW'(off) < cnt_q) && (fifo_addr_q[gi] == bus.rd_addr);
  end
  assign raw_hit = |hit_vec;
`else
  assign raw_hit = 1'b0;
`endif

  always_comb begin
    fifo_ne = (cnt_q != '0);
    forced  = (cnt_q >= CW'(HI_WM));
    rd_elig = bus.rd_req && !raw_hit;
    gnt     = GNT_NONE;
    if (forced)                  gnt = GNT_WR;
    else if (fifo_ne && rd_elig) gnt = (last_q == LAST_WR) ? GNT_RD : GNT_WR;
    else if (fifo_ne)            gnt = GNT_WR;
    else if (rd_elig)            gnt = GNT_RD;
  end

  always_comb begin
    pop    = (gnt == GNT_WR);
    full   = (cnt_q == CW'(FD));
    push   = bus.wr_vld && (!full || pop);
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    ovf_d  = ovf_q || (bus.wr_vld && full && !pop);

    last_d = last_q;
    if (gnt == GNT_WR)      last_d = LAST_WR;
    else if (gnt == GNT_RD) last_d = LAST_RD;

    // Address/data pins hold through idle cycles; only CE/WE drop.
    sram_en_d   = 1'b0;
    sram_wr_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    if (gnt == GNT_WR) begin
      sram_en_d   = 1'b1;
      sram_wr_d   = 1'b1;
      sram_addr_d = fifo_addr_q[rptr_q];
      sram_din_d  = fifo_data_q[rptr_q];
    end else if (gnt == GNT_RD) begin
      sram_en_d   = 1'b1;
      sram_addr_d = bus.rd_addr;
    end

    rd_vld_d = sram_en_q && !sram_wr_q;
  end

  always_ff @(posedge clk6) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= bus.wr_addr;
      fifo_data_q[wptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk6) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      last_q      <= LAST_WR;
      ovf_q       <= 1'b0;
      sram_en_q   <= 1'b0;
      sram_wr_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ovf_q       <= ovf_d;
      sram_en_q   <= sram_en_d;
      sram_wr_q   <= sram_wr_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // SRAM Q is already a registered macro output, so it is forwarded while rd_vld marks it.
  assign bus.rd_data   = rd_vld_q ? bus.sram_dout : '0;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_gnt    = (gnt == GNT_RD);
  assign bus.sram_en   = sram_en_q;
  assign bus.sram_wr   = sram_wr_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_din  = sram_din_q;
  assign fifo_cnt      = cnt_q;
  assign wr_ovf        = ovf_q;
endmodule

// File: doc/bidin_sram_arb.md
Name: bidin_sram_arb

Overview:
- Arbitrates the single-port deinterleaver main SRAM (147456x6) between two requesters: the write stream from the de-interleave input side and the read stream toward the LDPC decoder.
- The write side cannot be stalled, so incoming writes are buffered in a small FIFO that is drained into the SRAM.
- The read side uses a request/grant handshake and receives data a fixed number of cycles after grant.
- Sits between main_man-style address generators and the sram147456x6 macro, and drives its CE/WE/A/D directly.

Parameters:
- WID, 6, data width of one soft-bit word.
- AW, 18, SRAM address width.
- FD, 4, write FIFO depth; power of 2, minimum 2.
- HI_WM, 3, FIFO occupancy at or above which writes are forced; 1 <= HI_WM <= FD.

Ports:
- clk6  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- wr_vld  in  1  write word present this cycle; never back-pressured.
- wr_addr  in  AW  write address.
- wr_data  in  WID  write data.
- rd_req  in  1  read request; requester holds rd_req and rd_addr stable until rd_gnt.
- rd_addr  in  AW  read address.
- rd_gnt  out  1  combinational; read accepted this cycle.
- rd_vld  out  1  read data valid, one-cycle pulse.
- rd_data  out  WID  read data, meaningful only while rd_vld is high.
- sram_addr  out  AW  to SRAM A, registered.
- sram_din  out  WID  to SRAM D, registered.
- sram_dout  in  WID  from SRAM Q; valid the cycle after an enabled read.
- sram_en  out  1  SRAM CE, active high, registered.
- sram_wr  out  1  SRAM WE, active high, registered.
- fifo_cnt  out  log2(FD)+1  current write-FIFO occupancy.
- wr_ovf  out  1  sticky overflow flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk6. Reset is synchronous and active-low on rst_n.
- Reset values: FIFO empty, fifo_cnt=0, sram_en=0, sram_wr=0, sram_addr=0, sram_din=0, rd_vld=0, rd_data=0, wr_ovf=0, last_gnt=WRITE.
  - Reset mid-operation discards FIFO contents and any in-flight read. No rd_vld is issued for it.
- Write FIFO: circular buffer with read and write pointers mod FD.
  - wr_vld pushes {wr_addr, wr_data} every cycle it is high.
  - If the FIFO is full and no pop occurs the same cycle, the word is dropped, wr_ovf is set, and fifo_cnt stays at FD.
  - Push and pop in the same cycle are both legal at any occupancy, including full. fifo_cnt is unchanged in that case.
- Arbitration is decided each cycle from the registered state, with at most one grant per cycle (GNT_NONE, GNT_WR or GNT_RD):
  - fifo_cnt >= HI_WM: GNT_WR.
  - Otherwise, FIFO non-empty and rd_req: grant the side opposite last_gnt (alternation).
  - Otherwise, FIFO non-empty only: GNT_WR.
  - Otherwise, rd_req only: GNT_RD.
  - Otherwise: GNT_NONE.
  - last_gnt updates only on GNT_WR or GNT_RD.
- Effect of each grant:
  - GNT_WR pops the FIFO head.
  - GNT_RD asserts rd_gnt in the same cycle.
- SRAM drive, one cycle after the grant cycle:
  - GNT_WR: sram_en=1, sram_wr=1, sram_addr/sram_din = popped entry.
  - GNT_RD: sram_en=1, sram_wr=0, sram_addr=rd_addr.
  - GNT_NONE: sram_en=0, sram_wr=0; sram_addr and sram_din hold their previous values.
- Read latency: if rd_gnt is high in cycle n, the SRAM is accessed in n+1, and rd_vld=1 with rd_data=sram_dout (registered) in n+2.
  - Back-to-back grants give back-to-back rd_vld.
- Starvation: reads may be starved only while wr_vld keeps fifo_cnt >= HI_WM. Once fifo_cnt < HI_WM, the maximum wait between grants of a requesting side is 1 cycle.
- Write ordering: writes reach the SRAM strictly in arrival order.
- Read/write ordering: a read granted before a given write is popped sees the old data. Hazard protection is provided only by the optional feature.

Optional Feature:
- Macro: BIDIN_ARB_RAW_CHK_EN.
- Defined: a read is not granted while rd_addr matches the address of any valid FIFO entry. Such a read is treated as not requesting, so pending writes drain. It is granted in the cycle after the last matching entry is popped, preserving read-after-write order.
- Not defined: no address compare. Arbitration is exactly as above, and a read may return pre-write data.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, fifo_cnt=0, sram_en never high.
- Single write addr 0x00010, data 6'h2A with rd_req=0 -> sram_en=sram_wr=1, sram_addr=0x00010, sram_din=0x2A exactly 2 cycles after wr_vld; fifo_cnt returns to 0.
- Preload SRAM model addr 0x23FFF=6'h15, rd_req with no writes -> rd_gnt same cycle; rd_vld with rd_data=0x15 two cycles later; 8 consecutive reads give 8 consecutive rd_vld.
- wr_vld every other cycle with continuous rd_req -> grants alternate WR/RD; fifo_cnt never exceeds 1; no wr_ovf.
- wr_vld continuous for 20 cycles with rd_req held -> fifo_cnt settles at HI_WM-1 or HI_WM; reads are granted only between forced writes; no overflow. With the FIFO forced full while wr_vld is high and no pop (test hook), wr_ovf=1 and stays 1 until rst_n=0.
- Write addr 0x00100=6'h3F, then read addr 0x00100 the next cycle (FIFO contains it) -> with BIDIN_ARB_RAW_CHK_EN: rd_data=0x3F; without it: rd_data=old value 0x00. rst_n low during the pending read: no rd_vld, FIFO empty.
